// File: rtl/tcb_gpio_irq_if.sv
// -----------------------------------------------------------------------------
// tcb_if : TCB bus interface bundle shared by managers and subordinates.
//
// Parameters
//   AW  : address width
//   DW  : data width
//   DLY : read response latency in clock cycles
//
// Ports
//   clk : bus clock, the only clock of anything attached to this bus
//   rst : synchronous active-high reset
//
// Members
//   trn : transfer request
//   wen : write enable (1 = write, 0 = read)
//   adr : byte address
//   wdt : write data
//   rdt : read data, valid DLY cycles after the request
//   rdy : subordinate ready
//   err : subordinate error
// -----------------------------------------------------------------------------
interface tcb_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1
)(
    input logic clk,
    input logic rst
);

    logic          trn;
    logic          wen;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdt;
    logic [DW-1:0] rdt;
    logic          rdy;
    logic          err;

    modport man (
        input  clk,
        input  rst,
        output trn,
        output wen,
        output adr,
        output wdt,
        input  rdt,
        input  rdy,
        input  err
    );

    modport sub (
        input  clk,
        input  rst,
        input  trn,
        input  wen,
        input  adr,
        input  wdt,
        output rdt,
        output rdy,
        output err
    );

endinterface : tcb_if

// File: rtl/tcb_gpio_irq.sv
// -----------------------------------------------------------------------------
// tcb_gpio_irq : GPIO edge-interrupt controller with a TCB register port.
//
// Samples an already-synchronized GPIO vector, detects per-pin rising and
// falling edges, latches enabled edges into a pending register and drives one
// level-sensitive interrupt line.
//
// Parameters
//   GW          : GPIO width, must not exceed tcb.DW
//   CFG_RSP_REG : registered read response, must be 1 (bus latency DLY=1)
//
// Ports
//   tcb    : TCB subordinate (clk, rst, trn, wen, adr, wdt in; rdt, rdy, err out)
//   gpio_i : GPIO input vector, synchronous to tcb.clk
//   irq    : interrupt request, level, active-high
//
// Register map (offset on adr[4:0], GW bits, zero-extended on read)
//   0x00 IE   : interrupt enable mask          RW
//   0x04 RISE : rising-edge select mask        RW
//   0x08 FALL : falling-edge select mask       RW
//   0x0C PEND : pending flags                  R / write-1-to-clear
//   0x10 STAT : current gpio_i                 RO
// -----------------------------------------------------------------------------
module tcb_gpio_irq #(
    parameter int unsigned GW          = 32,
    parameter bit          CFG_RSP_REG = 1'b1
)(
    tcb_if.sub             tcb,
    input  logic [GW-1:0]  gpio_i,
    output logic           irq
);

    localparam int unsigned DW = tcb.DW;

    localparam logic [4:0] OFF_IE   = 5'h00;
    localparam logic [4:0] OFF_RISE = 5'h04;
    localparam logic [4:0] OFF_FALL = 5'h08;
    localparam logic [4:0] OFF_PEND = 5'h0C;
    localparam logic [4:0] OFF_STAT = 5'h10;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (GW > DW) begin : g_err_gw
            $error("tcb_gpio_irq: GW must not exceed tcb.DW");
        end
        if ((CFG_RSP_REG != 1'b1) || (tcb.DLY != 1)) begin : g_err_dly
            $error("tcb_gpio_irq: only a registered read response with tcb.DLY=1 is supported");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [GW-1:0] r_ie;
    logic [GW-1:0] r_rise;
    logic [GW-1:0] r_fall;
    logic [GW-1:0] r_pend;
    logic [GW-1:0] r_gpio_d;
    logic          r_arm;
    logic [DW-1:0] r_rdt;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic          w_wr;
    logic          w_rd;
    logic [4:0]    w_off;
    logic [GW-1:0] w_wdt;
    logic [GW-1:0] w_clr;
    logic          w_unused;

    assign w_wr  = tcb.trn &  tcb.wen;
    assign w_rd  = tcb.trn & ~tcb.wen;
    assign w_off = tcb.adr[4:0];
    assign w_wdt = tcb.wdt[GW-1:0];

    // Only the low address bits and the low GW data bits are decoded.
    assign w_unused = ^{tcb.adr, tcb.wdt};

    // Write-1-to-clear mask for the pending register.
    assign w_clr = (w_wr && (w_off == OFF_PEND)) ? w_wdt : '0;

    // -------------------------------------------------------------------------
    // Per-pin edge detection and pending update
    // -------------------------------------------------------------------------
    logic [GW-1:0] w_rise;
    logic [GW-1:0] w_fall;
    logic [GW-1:0] w_set;
    logic [GW-1:0] w_pend_next;

    genvar gi;
    generate
        for (gi = 0; gi < GW; gi++) begin : g_pin
            // Edges are suppressed until the first cycle after reset release so
            // pins already high while in reset do not look like rising edges.
            assign w_rise[gi] = r_arm &  gpio_i[gi] & ~r_gpio_d[gi];
            assign w_fall[gi] = r_arm & ~gpio_i[gi] &  r_gpio_d[gi];

            // Uses the masks as registered before any write in this cycle.
            assign w_set[gi]  = r_ie[gi] & ((r_rise[gi] & w_rise[gi]) |
                                            (r_fall[gi] & w_fall[gi]));

            // A new edge wins over a simultaneous clear of the same bit.
            assign w_pend_next[gi] = (r_pend[gi] & ~w_clr[gi]) | w_set[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read data mux
    // -------------------------------------------------------------------------
    logic [DW-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_IE:   w_rdata[GW-1:0] = r_ie;
            OFF_RISE: w_rdata[GW-1:0] = r_rise;
            OFF_FALL: w_rdata[GW-1:0] = r_fall;
            OFF_PEND: w_rdata[GW-1:0] = r_pend;
            OFF_STAT: w_rdata[GW-1:0] = gpio_i;
            default:  w_rdata         = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------
    always_ff @(posedge tcb.clk) begin
        if (tcb.rst) begin
            r_ie     <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_pend   <= '0;
            r_gpio_d <= '0;
            r_arm    <= 1'b0;
            r_rdt    <= '0;
        end else begin
            r_gpio_d <= gpio_i;
            r_arm    <= 1'b1;
            r_pend   <= w_pend_next;

            if (w_wr) begin
                case (w_off)
                    OFF_IE:   r_ie   <= w_wdt;
                    OFF_RISE: r_rise <= w_wdt;
                    OFF_FALL: r_fall <= w_wdt;
                    default:  ;
                endcase
            end

            // Read data holds across writes and idle cycles.
            if (w_rd) begin
                r_rdt <= w_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign irq     = |(r_pend & r_ie);
    assign tcb.rdt = r_rdt;
    assign tcb.rdy = 1'b1;
    assign tcb.err = 1'b0;

endmodule : tcb_gpio_irq

// File: tb/tb_tcb_gpio_irq.sv
// -----------------------------------------------------------------------------
// tb_tcb_gpio_irq : directed self-checking bench for tcb_gpio_irq.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tcb_gpio_irq;

    localparam logic [31:0] A_IE   = 32'h00;
    localparam logic [31:0] A_RISE = 32'h04;
    localparam logic [31:0] A_FALL = 32'h08;
    localparam logic [31:0] A_PEND = 32'h0C;
    localparam logic [31:0] A_STAT = 32'h10;
    localparam logic [31:0] A_NONE = 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_i;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcb_if #(.AW(32), .DW(32), .DLY(1)) tcb (.clk(clk), .rst(rst));

    tcb_gpio_irq #(
        .GW          (32),
        .CFG_RSP_REG (1'b1)
    ) dut (
        .tcb    (tcb),
        .gpio_i (gpio_i),
        .irq    (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        tcb.trn = 1'b1;
        tcb.wen = 1'b1;
        tcb.adr = adr;
        tcb.wdt = dat;
        tick();
        tcb.trn = 1'b0;
        tcb.wen = 1'b0;
        $display("wr adr=%h wdt=%h irq=%0b", adr, dat, irq);
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        tcb.trn = 1'b1;
        tcb.wen = 1'b0;
        tcb.adr = adr;
        tick();
        tcb.trn = 1'b0;
        $display("rd adr=%h rdt=%h exp=%h", adr, tcb.rdt, exp);
        check(tag, tcb.rdt, exp);
    endtask

    initial begin
        rst     = 1'b1;
        tcb.trn = 1'b0;
        tcb.wen = 1'b0;
        tcb.adr = '0;
        tcb.wdt = '0;
        gpio_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        tick(); tick(); tick();

        // Reset state
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdt", tcb.rdt, 32'd0);
        check("rdy",     {31'd0, tcb.rdy}, 32'd1);
        check("err",     {31'd0, tcb.err}, 32'd0);

        // No phantom edges from pins high through reset
        rst = 1'b0;
        tick();
        wr(A_IE,   32'hFFFF_FFFF);
        wr(A_RISE, 32'hFFFF_FFFF);
        tick(); tick();
        check("phantom_irq", {31'd0, irq}, 32'd0);
        rd("phantom_pend", A_PEND, 32'd0);
        wr(A_IE,   32'd0);
        wr(A_RISE, 32'd0);
        gpio_i = 32'd0;
        tick();

        // Rising edge on bit 0
        wr(A_IE,   32'h1);
        wr(A_RISE, 32'h1);
        check("b0_irq_before", {31'd0, irq}, 32'd0);
        gpio_i = 32'h1;
        tick();
        check("b0_irq", {31'd0, irq}, 32'd1);
        rd("b0_pend", A_PEND, 32'h1);
        wr(A_PEND, 32'h1);
        check("b0_irq_clr", {31'd0, irq}, 32'd0);
        rd("b0_pend_clr", A_PEND, 32'h0);

        // Edge in the same cycle as the IE write uses the old IE
        wr(A_RISE, 32'h3);
        tcb.trn = 1'b1; tcb.wen = 1'b1; tcb.adr = A_IE; tcb.wdt = 32'h2;
        gpio_i  = 32'h3;
        tick();
        tcb.trn = 1'b0; tcb.wen = 1'b0;
        check("oldmask_irq", {31'd0, irq}, 32'd0);
        rd("oldmask_pend", A_PEND, 32'h0);
        gpio_i = 32'h1;
        tick();
        gpio_i = 32'h3;
        tick();
        check("newmask_irq", {31'd0, irq}, 32'd1);
        wr(A_PEND, 32'h2);
        check("newmask_clr", {31'd0, irq}, 32'd0);

        // Falling edge on bit 7
        wr(A_RISE, 32'h0);
        wr(A_FALL, 32'h80);
        wr(A_IE,   32'h80);
        gpio_i = 32'h83;
        tick();
        check("b7_rise_ignored", {31'd0, irq}, 32'd0);
        gpio_i = 32'h03;
        tick();
        check("b7_irq", {31'd0, irq}, 32'd1);
        rd("b7_pend", A_PEND, 32'h80);
        wr(A_PEND, 32'h80);
        check("b7_irq_clr", {31'd0, irq}, 32'd0);

        // Clear of bit 3 coinciding with a new rising edge on bit 3
        wr(A_IE,   32'h08);
        wr(A_RISE, 32'h08);
        gpio_i = 32'h0B;
        tick();
        check("b3_irq", {31'd0, irq}, 32'd1);
        gpio_i = 32'h03;
        tick();
        check("b3_fall_hold", {31'd0, irq}, 32'd1);
        tcb.trn = 1'b1; tcb.wen = 1'b1; tcb.adr = A_PEND; tcb.wdt = 32'h08;
        gpio_i  = 32'h0B;
        tick();
        tcb.trn = 1'b0; tcb.wen = 1'b0;
        check("b3_set_wins_irq", {31'd0, irq}, 32'd1);
        rd("b3_set_wins_pend", A_PEND, 32'h08);
        wr(A_PEND, 32'h08);
        check("b3_irq_clr", {31'd0, irq}, 32'd0);
        rd("b3_pend_clr", A_PEND, 32'h0);

        // Masking a pending bit 5
        wr(A_IE,   32'h20);
        wr(A_RISE, 32'h20);
        gpio_i = 32'h2B;
        tick();
        check("b5_irq", {31'd0, irq}, 32'd1);
        wr(A_IE, 32'h0);
        check("b5_masked_irq", {31'd0, irq}, 32'd0);
        rd("b5_masked_pend", A_PEND, 32'h20);
        wr(A_IE, 32'h20);
        check("b5_unmasked_irq", {31'd0, irq}, 32'd1);
        wr(A_PEND, 32'h20);
        check("b5_irq_clr", {31'd0, irq}, 32'd0);

        // STAT, unmapped offset, read-data hold, ignored writes
        wr(A_IE, 32'h0);
        gpio_i = 32'hA5A5_A5A5;
        tick();
        rd("stat", A_STAT, 32'hA5A5_A5A5);
        tick();
        check("rdt_hold_idle", tcb.rdt, 32'hA5A5_A5A5);
        rd("unmapped", A_NONE, 32'h0);
        wr(A_STAT, 32'h1234_5678);
        check("rdt_hold_wr", tcb.rdt, 32'h0);
        rd("stat_after_wr", A_STAT, 32'hA5A5_A5A5);
        rd("ie_rb",   A_IE,   32'h0);
        rd("rise_rb", A_RISE, 32'h20);
        rd("fall_rb", A_FALL, 32'h80);
        rd("pend_rb", A_PEND, 32'h0);

        // Reset in mid-operation
        wr(A_IE, 32'h20);
        gpio_i = 32'h0;
        tick();
        gpio_i = 32'h20;
        tick();
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        rd("pre_rst_stat", A_STAT, 32'h20);
        rst    = 1'b1;
        gpio_i = 32'hFFFF_FFFF;
        tick();
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_rdt", tcb.rdt, 32'd0);
        rst = 1'b0;
        tick();
        wr(A_IE,   32'hFFFF_FFFF);
        wr(A_RISE, 32'hFFFF_FFFF);
        tick();
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        rd("post_rst_pend", A_PEND, 32'h0);
        rd("post_rst_fall", A_FALL, 32'h0);
        gpio_i = 32'h0;
        tick();
        gpio_i = 32'h1;
        tick();
        check("post_rst_edge_irq", {31'd0, irq}, 32'd1);
        rd("post_rst_edge_pend", A_PEND, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tcb_gpio_irq

// File: doc/tcb_gpio_irq.md
# tcb_gpio_irq

GPIO interrupt controller sitting directly downstream of the GPIO controller's input synchronizer. It samples the already-synchronized GPIO input vector, detects per-pin rising/falling edges, latches them into a pending register and drives a single level interrupt line to the CPU. Firmware configures and services it through a TCB subordinate port at its own address window, next to the GPIO controller on the same TCB interconnect.

## Interface
Parameters:
- GW, 32, GPIO width; must be <= tcb.DW (elaboration error otherwise)
- CFG_RSP_REG, 1'b1, registered read response; must match tcb.DLY=1 (elaboration error otherwise)

Ports:
- tcb.clk  input  1  clock (TCB interface member); the only clock
- tcb.rst  input  1  reset, synchronous, active-high (TCB interface member)
- gpio_i  input  GW  GPIO input vector, already synchronized to tcb.clk; no CDC inside this block
- irq  output  GW-independent 1  interrupt request, level, active-high
- tcb  tcb_if.sub  -  TCB subordinate: trn, wen, adr, wdt in; rdt, rdy, err out

## Operation
- Register map, decoded on tcb.adr[5-1:0], all GW bits wide, zero-extended to tcb.DW on read:
  - 0x00 IE: interrupt enable mask, RW
  - 0x04 RISE: rising-edge select mask, RW
  - 0x08 FALL: falling-edge select mask, RW
  - 0x0C PEND: pending flags, read; write-1-to-clear
  - 0x10 STAT: current gpio_i, read-only; writes ignored
  - other offsets: writes ignored, reads return 0
- Edge detection: gpio_d <= gpio_i every cycle; rise = gpio_i & ~gpio_d; fall = ~gpio_i & gpio_d.
- Arm flag: arm reset 0, set to 1 the first cycle after reset release; while arm==0 rise/fall are forced to 0 (no spurious edges from pins already high at reset).
- Set vector: set = IE & ((RISE & rise) | (FALL & fall)); RISE and FALL both set on a pin -> any edge.
- PEND update per bit: PEND <= (PEND & ~clr) | set, where clr = wdt[GW-1:0] on a write to 0x0C, else 0. Set wins over simultaneous clear.
- Clearing IE does not clear PEND; masked pending bits stay readable but do not drive irq.
- irq = |(PEND & IE), combinational from registers.
- Mask register writes take effect the cycle after the write; an edge sampled in the write cycle uses old masks.
- tcb.rdy = 1 constantly; tcb.err = 0 constantly.

## Timing
- Reset values: IE, RISE, FALL, PEND, gpio_d, arm = 0; tcb.rdt = 0; irq = 0.
- Read latency 1 (DLY=1): tcb.rdt updated at the clock edge where trn & ~wen; holds its value on writes and idle cycles.
- Read of PEND returns the value before that edge's update (set/clear in the same cycle not visible).
- Edge latency: gpio_i change visible at clock edge n -> PEND bit set at edge n -> irq high during cycle n+1 (given IE, select set and arm==1).
- Clear latency: W1C write at edge m -> irq low during cycle m+1 unless another bit remains pending or a new edge coincides.
- Synchronous reset mid-operation: all state returns to reset values at that edge; irq low next cycle; edges during the cycle after reset release are suppressed by arm.

## Test plan
- Reset with gpio_i=0xFFFF_FFFF, IE=RISE=all-ones written after reset -> PEND stays 0, irq stays 0 (no phantom edges).
- IE=0x1, RISE=0x1; drive gpio_i[0] 0->1 -> PEND=0x1, irq=1 one cycle after the edge; read PEND returns 0x0000_0001 with 1-cycle latency.
- FALL=0x80, IE=0x80; gpio_i[7] 1->0, then write 0x80 to 0x0C -> irq 1 then 0 the cycle after the write.
- W1C of bit 3 in the same cycle as a new enabled rising edge on bit 3 -> PEND[3] stays 1, irq stays 1.
- Pending bit 5 with IE[5]=1, then write IE=0 -> irq 0, PEND reads 0x20; re-enable IE[5] -> irq 1 again.
- Read STAT with gpio_i=0xA5A5_A5A5 -> rdt=0xA5A5_A5A5 next cycle; read offset 0x14 -> 0; write 0x10 -> no register change.
